ps2_dir_decoder: RTL and testbench
==================================

// Module: ps2_dir_decoder
// PURPOSE
//   Upstream input stage of the snake game. Receives PS/2 keyboard frames (scan code set 2) on
//   ps2_clk/ps2_data, assembles bytes and tracks E0/F0 prefixes. Converts make codes for
//   W/A/S/D, arrow keys and Space into a registered direction and one-cycle command pulses,
//   which the game-logic stage consumes.
// PARAMETERS
//   TIMEOUT_CYC  25000  clk cycles with no ps2_clk falling edge before a partial frame is dropped (1 ms @ 25 MHz)
//   SYNC_STAGES  2      flip-flop stages on ps2_clk and ps2_data (minimum 2)
// PORTS
//   clk          in   1  system clock, 25 MHz; the only clock
//   rst          in   1  synchronous, active-high reset
//   ps2_clk      in   1  asynchronous PS/2 clock from keyboard
//   ps2_data     in   1  asynchronous PS/2 data from keyboard
//   dir          out  2  last direction: 00 up, 01 down, 10 left, 11 right
//   dir_valid    out  1  one-cycle pulse; dir was just written (repeats are also pulsed)
//   start_pulse  out  1  one-cycle pulse on Space make code (0x29)
//   byte_data    out  8  last received byte
//   byte_valid   out  1  one-cycle pulse; byte_data updated
//   frame_err    out  1  one-cycle pulse; frame dropped (bad start/stop bit, timeout, parity when enabled)
// BEHAVIOUR
//   - Reset values: dir=2'b11, byte_data=8'h00; all pulses 0; frame FSM IDLE; ext/brk flags 0; timeout counter 0.
//   - Both PS/2 inputs pass through SYNC_STAGES FFs. A falling edge is detected when the previous synced ps2_clk is 1 and the current one is 0.
//   - Frame FSM, sampling on each falling edge: IDLE -> START (bit must be 0, else frame_err, back to IDLE)
//     -> DATA x8 (LSB first) -> PARITY -> STOP (bit must be 1, else frame_err, back to IDLE).
//   - byte_valid rises on the cycle after the edge that samples the stop bit.
//   - Timeout: counter clears on every falling edge and in IDLE. If the FSM is not IDLE and the counter
//     reaches TIMEOUT_CYC-1, the FSM goes to IDLE and frame_err pulses. A bit captured on the same cycle wins over the timeout.
//   - Prefix tracker, processing the byte on the cycle after byte_valid:
//     0xE0 -> ext=1; 0xF0 -> brk=1. Any other byte: if brk, it is a release and is ignored.
//     Otherwise it is mapped (see below). Both flags are cleared after any non-prefix byte.
//   - Key map with ext=0: 1D->up, 1B->down, 1C->left, 23->right, 29->start_pulse.
//     Key map with ext=1: 75->up, 72->down, 6B->left, 74->right.
//     Unmapped codes produce no pulse.
//   - Latency: dir and dir_valid update 2 cycles after the stop-bit edge is detected.
//     dir_valid or start_pulse lasts exactly 1 cycle.
//   - Typematic repeats from the keyboard produce repeated dir_valid pulses. Rejecting a reversal of direction is the consumer's job, not this block's.
//   - When rst is asserted mid-frame, the partial frame is discarded with no frame_err pulse. The first falling edge after reset is treated as a start bit.
// CONFIGURATION
//   PS2_PARITY_CHECK_EN defined: a parity bit that does not make the 9 bits odd drops the byte.
//     No byte_valid is produced and frame_err pulses in the same cycle byte_valid would have risen.
//   PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored.
// STRUCTURE
//   - Shared package snake_pkg holds:
//     - direction constants DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT
//     - scan-code constants SC_W/A/S/D, SC_UP/DOWN/LEFT/RIGHT, SC_SPACE, SC_EXT=8'hE0, SC_BRK=8'hF0
//   - One sub-module, ps2_rx_frame, contains the synchronisers, edge detect, frame FSM and timeout.
//     It outputs byte_data, byte_valid and frame_err.
//   - The top level adds the prefix tracker and the key map.
// TESTING
//   1. Send 0x1D (frame 0,10111000,parity 1,1; 12.5 kHz PS/2 clock) -> byte_valid with 8'h1D, then dir=00 with one dir_valid pulse.
//   2. Send E0,74 then E0,F0,74 -> exactly one dir_valid with dir=11; the release sequence produces no pulse and leaves dir unchanged.
//   3. Send 0x29 -> start_pulse high exactly 1 cycle; dir and dir_valid unchanged.
//   4. Stop ps2_clk after 5 bits for longer than 25000 cycles -> frame_err 1 pulse; a following 0x1C frame gives dir=10.
//   5. With the macro defined, send 0x23 with parity=0 -> no byte_valid and frame_err pulse.
//      With the macro undefined, the same frame gives dir=11.
//   6. Assert rst for 1 cycle mid-frame -> all outputs at reset values, no frame_err; the next full 0x1B frame gives dir=01.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: shared direction codes, PS/2 set-2 scan codes, receiver FSM states and key-map helper
package snake_pkg;
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef struct packed {
    logic       hit;
    logic [1:0] dir;
  } key_t;
  // WASD are plain codes; arrows only count when preceded by E0.
  function automatic key_t map_key(input logic ext, input logic [7:0] code);
    key_t k;
    k.hit = 1'b1;
    k.dir = DIR_UP;
    if ((!ext && code == SC_W) || (ext && code == SC_UP)) k.dir = DIR_UP;
    else if ((!ext && code == SC_S) || (ext && code == SC_DOWN)) k.dir = DIR_DOWN;
    else if ((!ext && code == SC_A) || (ext && code == SC_LEFT)) k.dir = DIR_LEFT;
    else if ((!ext && code == SC_D) || (ext && code == SC_RIGHT)) k.dir = DIR_RIGHT;
    else k.hit = 1'b0;
    return k;
  endfunction
endpackage

// File: rtl/ps2_dir_decoder_if.sv
// ps2_dir_decoder_if: PS/2 pins plus decoded direction/command/byte outputs.
//   master: the decoder (reads ps2_clk/ps2_data, drives dir, dir_valid, start_pulse, byte_data, byte_valid, frame_err)
//   slave : keyboard/consumer side (drives the PS/2 pins, reads the decoded outputs)
interface ps2_dir_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [1:0] dir;
  logic       dir_valid;
  logic       start_pulse;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  modport master(input ps2_clk, ps2_data, output dir, dir_valid, start_pulse, byte_data, byte_valid, frame_err);
  modport slave(output ps2_clk, ps2_data, input dir, dir_valid, start_pulse, byte_data, byte_valid, frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronises PS/2 clk/data, samples 11-bit frames on ps2_clk falling edges, drops stalled frames.
//   in : clk, rst (sync, active high), ps2_clk, ps2_data (async)
//   out: byte_data (last good byte), byte_valid (1-cycle), frame_err (1-cycle)
//   PS2_PARITY_CHECK_EN: when defined, a frame with even parity over data+parity is dropped as an error.
module ps2_rx_frame
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYC = 25000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic clk_prev_q, clk_prev_d;
  rx_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bv_q, bv_d, fe_q, fe_d;
  logic fall, bit_in, par_bad;
`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  assign par_bad = ~^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif
  // Synchronisers reset to 0 so a line held low across reset cannot fake a falling edge.
  assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_in = data_sync_q[SYNC_STAGES-1];
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    state_d     = state_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_d       = (fall || state_q == RX_IDLE) ? '0 : cnt_q + CW'(1);
    bv_d        = 1'b0;
    fe_d        = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d       = par_q;
`endif
    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          state_d   = bit_in ? RX_IDLE : RX_DATA;
          fe_d      = bit_in;
          bit_cnt_d = '0;
        end
        RX_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == 3'd7) ? RX_PARITY : RX_DATA;
        end
        RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = bit_in;
`endif
          state_d = RX_STOP;
        end
        default: begin
          state_d = RX_IDLE;
          fe_d    = ~bit_in | par_bad;
          bv_d    = bit_in & ~par_bad;
          byte_d  = (bit_in & ~par_bad) ? shift_q : byte_q;
        end
      endcase
    end else if (state_q != RX_IDLE && cnt_q == CW'(TIMEOUT_CYC - 1)) begin
      state_d = RX_IDLE;
      fe_d    = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      state_q     <= RX_IDLE;
      shift_q     <= '0;
      byte_q      <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      bv_q        <= 1'b0;
      fe_q        <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      bv_q        <= bv_d;
      fe_q        <= fe_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= par_d;
`endif
    end
  end
  assign byte_data  = byte_q;
  assign byte_valid = bv_q;
  assign frame_err  = fe_q;
endmodule

// File: rtl/ps2_dir_decoder.sv
// ps2_dir_decoder: PS/2 keyboard front end for the snake game; turns WASD/arrow/Space make codes into dir + pulses.
//   in : clk, rst (sync, active high), bus.ps2_clk, bus.ps2_data
//   out: bus.dir, bus.dir_valid, bus.start_pulse, bus.byte_data, bus.byte_valid, bus.frame_err
//   PS2_PARITY_CHECK_EN: enables parity checking in ps2_rx_frame.
module ps2_dir_decoder
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYC = 25000,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  ps2_dir_decoder_if.master bus
);
  logic [7:0] rx_byte;
  logic rx_valid, rx_err;
  logic ext_q, ext_d, brk_q, brk_d, dv_q, dv_d, sp_q, sp_d;
  logic [1:0] dir_q, dir_d;
  key_t k;
  ps2_rx_frame #(.TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk(clk), .rst(rst), .ps2_clk(bus.ps2_clk), .ps2_data(bus.ps2_data),
    .byte_data(rx_byte), .byte_valid(rx_valid), .frame_err(rx_err)
  );
  // Prefixes only set flags; the next non-prefix byte consumes and clears both.
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    dir_d = dir_q;
    dv_d  = 1'b0;
    sp_d  = 1'b0;
    k     = map_key(ext_q, rx_byte);
    if (rx_valid) begin
      if (rx_byte == SC_EXT) ext_d = 1'b1;
      else if (rx_byte == SC_BRK) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        dv_d  = ~brk_q & k.hit;
        dir_d = (~brk_q & k.hit) ? k.dir : dir_q;
        sp_d  = ~brk_q & ~ext_q & (rx_byte == SC_SPACE);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      dir_q <= DIR_RIGHT;
      dv_q  <= 1'b0;
      sp_q  <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      dir_q <= dir_d;
      dv_q  <= dv_d;
      sp_q  <= sp_d;
    end
  end
  assign bus.dir         = dir_q;
  assign bus.dir_valid   = dv_q;
  assign bus.start_pulse = sp_q;
  assign bus.byte_data   = rx_byte;
  assign bus.byte_valid  = rx_valid;
  assign bus.frame_err   = rx_err;
endmodule

// File: tb/tb_ps2_dir_decoder.sv
// tb_ps2_dir_decoder: directed PS/2 frames with hand-computed expectations for ps2_dir_decoder.
module tb_ps2_dir_decoder;
  localparam int H = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ps2_dir_decoder_if bus();
  ps2_dir_decoder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_dv = 0, n_sp = 0, n_bv = 0, n_fe = 0, bv_cyc = 0, dv_cyc = 0;
  logic [7:0] last_byte = 8'h00;
  int dv0, sp0, bv0, fe0;
  always @(negedge clk) begin
    cyc++;
    if (bus.dir_valid === 1'b1) begin n_dv++; dv_cyc = cyc; end
    if (bus.start_pulse === 1'b1) n_sp++;
    if (bus.frame_err === 1'b1) n_fe++;
    if (bus.byte_valid === 1'b1) begin n_bv++; bv_cyc = cyc; last_byte = bus.byte_data; end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic snap();
    dv0 = n_dv; sp0 = n_sp; bv0 = n_bv; fe0 = n_fe;
  endtask
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = f[i];
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
  endtask
  function automatic logic [10:0] frame(input logic [7:0] b, input bit par_ok);
    logic p;
    p = par_ok ? ~^b : ^b;
    return {1'b1, p, b, 1'b0};
  endfunction
  task automatic send(input logic [7:0] b);
    send_bits(frame(b, 1'b1), 11);
    repeat (12) @(negedge clk);
  endtask
  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_dir", bus.dir, 2'b11);
    chk("rst_byte", bus.byte_data, 8'h00);
    chk("rst_pulses", {bus.dir_valid, bus.start_pulse, bus.byte_valid, bus.frame_err}, 4'b0000);
    snap();
    send_bits(11'b1_1_10111000_0 >> 0, 0);
    send(8'h1D);
    chk("t1_bv", n_bv - bv0, 1);
    chk("t1_byte", last_byte, 8'h1D);
    chk("t1_dv", n_dv - dv0, 1);
    chk("t1_dir", bus.dir, 2'b00);
    chk("t1_lat", dv_cyc - bv_cyc, 1);
    chk("t1_fe", n_fe - fe0, 0);
    snap();
    send(8'hE0); send(8'h74);
    chk("t2_dv", n_dv - dv0, 1);
    chk("t2_dir", bus.dir, 2'b11);
    snap();
    send(8'hE0); send(8'hF0); send(8'h74);
    chk("t2_rel_bv", n_bv - bv0, 3);
    chk("t2_rel_dv", n_dv - dv0, 0);
    chk("t2_rel_dir", bus.dir, 2'b11);
    snap();
    send(8'hF0); send(8'h1D);
    chk("brk_w_dv", n_dv - dv0, 0);
    chk("brk_w_dir", bus.dir, 2'b11);
    snap();
    send(8'h29);
    chk("t3_sp", n_sp - sp0, 1);
    chk("t3_dv", n_dv - dv0, 0);
    chk("t3_dir", bus.dir, 2'b11);
    snap();
    send(8'h75); send(8'hE0); send(8'h1D); send(8'hE0); send(8'h29);
    chk("unmapped_dv", n_dv - dv0, 0);
    chk("unmapped_sp", n_sp - sp0, 0);
    chk("unmapped_dir", bus.dir, 2'b11);
    snap();
    send_bits(11'h7FF, 1);
    repeat (12) @(negedge clk);
    chk("bad_start_fe", n_fe - fe0, 1);
    chk("bad_start_bv", n_bv - bv0, 0);
    snap();
    send(8'h1D);
    snap();
    send_bits(frame(8'h1C, 1'b1), 5);
    repeat (24000) @(negedge clk);
    chk("t4_early_fe", n_fe - fe0, 0);
    repeat (2000) @(negedge clk);
    chk("t4_fe", n_fe - fe0, 1);
    chk("t4_bv", n_bv - bv0, 0);
    send(8'h1C);
    chk("t4_dir", bus.dir, 2'b10);
    chk("t4_dv", n_dv - dv0, 1);
    snap();
    send_bits(frame(8'h23, 1'b0), 11);
    repeat (12) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
    chk("t5_bv", n_bv - bv0, 0);
    chk("t5_fe", n_fe - fe0, 1);
    chk("t5_dir", bus.dir, 2'b10);
`else
    chk("t5_bv", n_bv - bv0, 1);
    chk("t5_fe", n_fe - fe0, 0);
    chk("t5_dir", bus.dir, 2'b11);
`endif
    send(8'h1D);
    chk("t6_pre_dir", bus.dir, 2'b00);
    snap();
    send_bits(frame(8'h1B, 1'b1), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_dir", bus.dir, 2'b11);
    chk("t6_byte", bus.byte_data, 8'h00);
    repeat (100) @(negedge clk);
    chk("t6_fe", n_fe - fe0, 0);
    send(8'h1B);
    chk("t6_dir_after", bus.dir, 2'b01);
    chk("t6_dv", n_dv - dv0, 1);
    chk("t6_byte_after", last_byte, 8'h1B);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
